// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS decode constants, ALU OP codes and control bundle for the ID/EX stage.
// Opcode and funct values are the raw instruction fields.
package id_ex_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_ADDU  = 4'b0100,
        ALU_SUBU  = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_MULT  = 4'b1000,
        ALU_MULTU = 4'b1001,
        ALU_LUI   = 4'b1010,
        ALU_SLTU  = 4'b1011,
        ALU_NOR   = 4'b1100,
        ALU_BRK   = 4'b1111
    } alu_op_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// Opcode/funct to 4-bit ALU OP decoder; purely combinational, no state.
// Latency: 0 cycles. Backpressure: none (decoder only).
// Unlisted encodings decode to AND (0000); invalid slots decode to 0000 so BRK never leaks.
module id_ex_stage_alu_control
    import id_ex_stage_pkg::*;
(
    input  logic       i_valid,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_op
);

    alu_op_e w_op;

    always_comb begin
        w_op = ALU_AND;
        if (i_opcode == OP_RTYPE) begin
            unique case (i_funct)
                FN_ADD:   w_op = ALU_ADD;
                FN_ADDU:  w_op = ALU_ADDU;
                FN_SUB:   w_op = ALU_SUB;
                FN_SUBU:  w_op = ALU_SUBU;
                FN_AND:   w_op = ALU_AND;
                FN_OR:    w_op = ALU_OR;
                FN_XOR:   w_op = ALU_XOR;
                FN_NOR:   w_op = ALU_NOR;
                FN_SLT:   w_op = ALU_SLT;
                FN_SLTU:  w_op = ALU_SLTU;
                FN_MULT:  w_op = ALU_MULT;
                FN_MULTU: w_op = ALU_MULTU;
                FN_BREAK: w_op = ALU_BRK;
                default:  w_op = ALU_AND;
            endcase
        end else begin
            unique case (i_opcode)
                OP_LW, OP_SW, OP_ADDI: w_op = ALU_ADD;
                OP_ADDIU:              w_op = ALU_ADDU;
                OP_SLTI:               w_op = ALU_SLT;
                OP_SLTIU:              w_op = ALU_SLTU;
                OP_ANDI:               w_op = ALU_AND;
                OP_ORI:                w_op = ALU_OR;
                OP_XORI:               w_op = ALU_XOR;
                OP_LUI:                w_op = ALU_LUI;
                OP_BEQ, OP_BNE:        w_op = ALU_SUB;
                default:               w_op = ALU_AND;
            endcase
        end
    end

    assign o_alu_op = i_valid ? w_op : ALU_AND;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU OP decode, EX/MEM + MEM/WB forwarding and load-use detect.
// Latency: 1 cycle ID->alu_op/control; alu_a/alu_b/store data combinational within EX.
// Backpressure: stall holds all regs, flush (wins over stall) loads a bubble.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [5:0]            id_opcode,
    input  logic [5:0]            id_funct,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [3:0]            alu_op,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  load_use_hazard
);

    logic                  r_valid;
    logic [3:0]            r_alu_op;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [REG_ADDR_W-1:0] r_dest;
    logic [DATA_W-1:0]     r_rs_data;
    logic [DATA_W-1:0]     r_rt_data;
    logic [DATA_W-1:0]     r_imm;
    logic                  r_alu_src;
    ctrl_t                 r_ctrl;

    logic [3:0]            w_alu_op;
    ctrl_t                 w_ctrl;
    logic [DATA_W-1:0]     w_fwd_rs;
    logic [DATA_W-1:0]     w_fwd_rt;

    id_ex_stage_alu_control u_alu_control (
        .i_valid  (id_valid),
        .i_opcode (id_opcode),
        .i_funct  (id_funct),
        .o_alu_op (w_alu_op)
    );

    assign w_ctrl = id_valid ? ctrl_t'{id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg}
                             : ctrl_t'('0);

    // A bubble clears the whole stage so a flushed slot never forwards stale operands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_alu_op  <= 4'b0000;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dest    <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_alu_src <= 1'b0;
            r_ctrl    <= '0;
        end else if (flush) begin
            r_valid   <= 1'b0;
            r_alu_op  <= 4'b0000;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dest    <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_alu_src <= 1'b0;
            r_ctrl    <= '0;
        end else if (!stall) begin
            r_valid   <= id_valid;
            r_alu_op  <= w_alu_op;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_dest    <= id_reg_dst ? id_rd : id_rt;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_alu_src <= id_alu_src;
            r_ctrl    <= w_ctrl;
        end
    end

    // EX/MEM is the younger producer, so it takes precedence; r0 is never forwarded.
    always_comb begin
        w_fwd_rs = r_rs_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs))
            w_fwd_rs = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs))
            w_fwd_rs = memwb_result;
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rt))
            w_fwd_rt = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rt))
            w_fwd_rt = memwb_result;
    end

    assign alu_a         = w_fwd_rs;
    assign alu_b         = r_alu_src ? r_imm : w_fwd_rt;
    assign alu_op        = r_alu_op;
    assign ex_valid      = r_valid;
    assign ex_store_data = w_fwd_rt;
    assign ex_dest       = r_dest;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;

    assign load_use_hazard = r_ctrl.mem_read && r_valid && (r_dest != '0) &&
                             ((r_dest == id_rs) || (r_dest == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then randomized traffic against a table-driven model.
module tb_id_ex_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall, flush, id_valid;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard;
    logic [4:0]  ex_dest;

    always #5 clock = ~clock;

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_valid(ex_valid),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_use_hazard(load_use_hazard)
    );

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [4:0]  rs, rt, dest;
        logic [31:0] rsd, rtd, imm;
        logic        src;
        logic [3:0]  ctl;   // {reg_write, mem_read, mem_write, mem_to_reg}
    } mdl_t;

    mdl_t        m;
    logic [3:0]  rtab [64];
    logic [3:0]  itab [64];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic v, input logic [5:0] opc, input logic [5:0] fn);
        if (!v) return 4'h0;
        return (opc == 6'h00) ? rtab[fn] : itab[opc];
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] stored);
        if (src == 5'd0) return stored;
        if (exmem_reg_write && exmem_rd == src) return exmem_result;
        if (memwb_reg_write && memwb_rd == src) return memwb_result;
        return stored;
    endfunction

    task automatic model_edge();
        if (flush) m = '0;
        else if (!stall) begin
            m.valid = id_valid;
            m.op    = ref_op(id_valid, id_opcode, id_funct);
            m.rs    = id_rs;
            m.rt    = id_rt;
            m.dest  = id_reg_dst ? id_rd : id_rt;
            m.rsd   = id_rs_data;
            m.rtd   = id_rt_data;
            m.imm   = id_imm;
            m.src   = id_alu_src;
            m.ctl   = id_valid ? {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} : 4'h0;
        end
    endtask

    task automatic check_all();
        logic [31:0] e_rt;
        logic        e_haz;
        e_rt  = fwd(m.rt, m.rtd);
        e_haz = m.ctl[2] && m.valid && (m.dest != 0) && (m.dest == id_rs || m.dest == id_rt);
        chk("alu_a", alu_a, fwd(m.rs, m.rsd));
        chk("alu_b", alu_b, m.src ? m.imm : e_rt);
        chk("alu_op", {28'd0, alu_op}, {28'd0, m.op});
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
        chk("store_data", ex_store_data, e_rt);
        chk("ex_dest", {27'd0, ex_dest}, {27'd0, m.dest});
        chk("ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, {28'd0, m.ctl});
        chk("hazard", {31'd0, load_use_hazard}, {31'd0, e_haz});
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic set_id(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic src, input logic dst, input logic [3:0] ctl);
        id_valid = v; id_opcode = opc; id_funct = fn;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_src = src; id_reg_dst = dst;
        {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = ctl;
    endtask

    task automatic clr_fwd();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic rand_id();
        logic [5:0] opcs [14];
        logic [5:0] fns  [14];
        opcs = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        fns  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                 6'h2A, 6'h2B, 6'h18, 6'h19, 6'h0D, 6'h3F};
        set_id(($urandom_range(0, 4) != 0),
               ($urandom_range(0, 7) == 0) ? 6'($urandom) : opcs[$urandom_range(0, 13)],
               ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 13)],
               5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
               $urandom, $urandom, $urandom,
               1'($urandom), 1'($urandom), 4'($urandom));
    endtask

    task automatic rand_fwd();
        exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 4)); exmem_result = $urandom;
        memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 4)); memwb_result = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin rtab[i] = 4'h0; itab[i] = 4'h0; end
        rtab[6'h20] = 4'b0010; rtab[6'h21] = 4'b0100; rtab[6'h22] = 4'b0110; rtab[6'h23] = 4'b0101;
        rtab[6'h24] = 4'b0000; rtab[6'h25] = 4'b0001; rtab[6'h26] = 4'b0011; rtab[6'h27] = 4'b1100;
        rtab[6'h2A] = 4'b0111; rtab[6'h2B] = 4'b1011; rtab[6'h18] = 4'b1000; rtab[6'h19] = 4'b1001;
        rtab[6'h0D] = 4'b1111;
        itab[6'h23] = 4'b0010; itab[6'h2B] = 4'b0010; itab[6'h08] = 4'b0010; itab[6'h09] = 4'b0100;
        itab[6'h0A] = 4'b0111; itab[6'h0B] = 4'b1011; itab[6'h0C] = 4'b0000; itab[6'h0D] = 4'b0001;
        itab[6'h0E] = 4'b0011; itab[6'h0F] = 4'b1010; itab[6'h04] = 4'b0110; itab[6'h05] = 4'b0110;

        m = '0;
        reset_n = 0; stall = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        clr_fwd();
        repeat (2) @(negedge clock);
        check_all();
        reset_n = 1;

        // add r3,r1,r2 with r1=5, r2=7
        set_id(1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0, 1, 4'b1000);
        step();
        chk("add_a", alu_a, 32'd5);
        chk("add_b", alu_b, 32'd7);
        chk("add_op", {28'd0, alu_op}, 32'h2);
        chk("add_dest", {27'd0, ex_dest}, 32'd3);

        // Forwarding priority on rs=1 while the stage is held
        stall = 1;
        set_id(0, 0, 0, 5'd9, 5'd9, 0, 0, 0, 0, 0, 0, 4'h0);
        exmem_reg_write = 1; exmem_rd = 5'd1; exmem_result = 32'h10;
        memwb_reg_write = 1; memwb_rd = 5'd1; memwb_result = 32'h20;
        #1 chk("fwd_exmem", alu_a, 32'h10);
        check_all();
        exmem_reg_write = 0;
        #1 chk("fwd_memwb", alu_a, 32'h20);
        exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1 chk("fwd_r0", alu_a, 32'd5);
        check_all();
        clr_fwd();
        stall = 0;

        // addiu with all-ones immediate, then sltu
        set_id(1, 6'h09, 6'h00, 5'd2, 5'd6, 5'd0, 32'd1, 32'd2, 32'hFFFF_FFFF, 1, 0, 4'b1000);
        step();
        chk("addiu_b", alu_b, 32'hFFFF_FFFF);
        chk("addiu_op", {28'd0, alu_op}, 32'h4);
        set_id(1, 6'h00, 6'h2B, 5'd1, 5'd2, 5'd7, 32'd3, 32'd4, 32'd0, 0, 1, 4'b1000);
        step();
        chk("sltu_op", {28'd0, alu_op}, 32'hB);

        // lw r4 in EX, ID consumer reads r4 -> hazard, then stall+flush -> bubble
        set_id(1, 6'h23, 6'h00, 5'd1, 5'd4, 5'd0, 32'h100, 32'd0, 32'd8, 1, 0, 4'b1101);
        step();
        set_id(1, 6'h00, 6'h20, 5'd2, 5'd4, 5'd5, 32'd1, 32'd1, 32'd0, 0, 1, 4'b1000);
        #1 chk("luse_hazard", {31'd0, load_use_hazard}, 32'd1);
        check_all();
        stall = 1; flush = 1;
        step();
        chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("bubble_op", {28'd0, alu_op}, 32'd0);
        stall = 0; flush = 0;

        // Three stalled cycles with changing ID inputs
        set_id(1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'd0, 0, 1, 4'b1000);
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            step();
            chk("hold_a", alu_a, 32'd11);
            chk("hold_op", {28'd0, alu_op}, 32'h2);
            chk("hold_dest", {27'd0, ex_dest}, 32'd3);
        end
        stall = 0;

        set_id(1, 6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 0, 1, 4'b1000);
        step();
        chk("unk_funct_op", {28'd0, alu_op}, 32'd0);

        // Asynchronous reset mid-stream
        set_id(1, 6'h0F, 6'h00, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h55, 1, 0, 4'b1001);
        step();
        #2 reset_n = 0;
        #1 m = '0;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_op", {28'd0, alu_op}, 32'd0);
        check_all();
        @(negedge clock);
        reset_n = 1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_id();
            rand_fwd();
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
